// File: rtl/matrix_wb_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mwb_pkg
// Shared types and default sizes for the matrix write-back sequencer.
//   mwb_state_e : sequencer state (IDLE: accept requests, SEQ: draining rows)
//   mwb_src_e   : source selected for a single-line matrix write
// ----------------------------------------------------------------------------
package mwb_pkg;

    localparam int MWB_ROWS   = 4;
    localparam int MWB_XLEN   = 32;
    localparam int MWB_MIDX_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } mwb_state_e;

    typedef enum logic [1:0] {
        SRC_LINE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_REG  = 2'd2
    } mwb_src_e;

endpackage

// File: rtl/matrix_wb_sequencer_row_buffer.sv
// ----------------------------------------------------------------------------
// mwb_row_buffer
// Holds rows 1..ROWS-1 of a MOPA result while row 0 is written directly.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (clears the buffer)
//   load       : capture load_rows this cycle
//   load_rows  : rows 1..ROWS-1 of the MOPA result (element i-1 = row i)
//   rd_idx     : row number to read, valid in 1..ROWS-1
//   rd_data    : combinational read of the selected row (0 for rd_idx = 0)
// ----------------------------------------------------------------------------
module mwb_row_buffer
    import mwb_pkg::*;
#(
    parameter int XLEN  = MWB_XLEN,
    parameter int ROWS  = MWB_ROWS,
    localparam int IDX_W = $clog2(ROWS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [ROWS-2:0][XLEN-1:0]      load_rows,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [XLEN-1:0]                rd_data
);

    logic [ROWS-2:0][XLEN-1:0] mem_r;
    logic [XLEN-1:0]           rd_data_s;

    // Capture storage: cleared on reset, loaded when a MOPA is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r <= '0;
        end else if (load) begin
            mem_r <= load_rows;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Read mux: row i lives at storage slot i-1; row 0 is never stored.
    always_comb begin
        rd_data_s = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data_s = mem_r[i-1];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/matrix_wb_sequencer.sv
// ----------------------------------------------------------------------------
// matrix_wb_sequencer
// Write-port controller between MEM/WB and the matrix register file (MRF).
// Single-line writes pass through with one cycle of latency; a MOPA result
// (ROWS lines) is serialised one row per cycle while the pipeline is stalled.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   wb_matrix_write          : single-line write request
//   wb_matrix_write_mopa     : full-matrix (MOPA) write request, wins over line
//   wb_matrix_index          : target matrix register
//   wb_matrix_row            : target row of a single-line write
//   wb_mem2matrix            : line source = wb_mem_data (highest priority)
//   wb_mem_reg2matrix        : line source = wb_regs_data1
//   wb_mem_data, wb_regs_data1, wb_matrix_line_data : line sources
//   wb_matrix_mul_o          : MOPA result rows (element r = row r)
//   mrf_we/sel/row/wdata     : registered MRF write port
//   stall                    : high while rows remain (state SEQ)
//   busy                     : state != IDLE or a write is being presented
// Optional feature (macro MWB_PERF_CNT_EN):
//   perf_stall_cnt           : saturating count of stalled cycles
// ----------------------------------------------------------------------------
module matrix_wb_sequencer
    import mwb_pkg::*;
#(
    parameter int XLEN   = MWB_XLEN,
    parameter int ROWS   = MWB_ROWS,
    parameter int MIDX_W = MWB_MIDX_W,
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_matrix_write,
    input  logic                      wb_matrix_write_mopa,
    input  logic [MIDX_W-1:0]         wb_matrix_index,
    input  logic [ROW_W-1:0]          wb_matrix_row,
    input  logic                      wb_mem2matrix,
    input  logic                      wb_mem_reg2matrix,
    input  logic [XLEN-1:0]           wb_mem_data,
    input  logic [XLEN-1:0]           wb_regs_data1,
    input  logic [XLEN-1:0]           wb_matrix_line_data,
    input  logic [ROWS-1:0][XLEN-1:0] wb_matrix_mul_o,
    output logic                      mrf_we,
    output logic [MIDX_W-1:0]         mrf_sel,
    output logic [ROW_W-1:0]          mrf_row,
    output logic [XLEN-1:0]           mrf_wdata,
    output logic                      stall,
    output logic                      busy
`ifdef MWB_PERF_CNT_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_SEQ   = SEQ;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [0:0]        state_r, state_s;
    logic [ROW_W-1:0]  cnt_r, cnt_s;
    logic              mrf_we_r, we_s;
    logic [MIDX_W-1:0] mrf_sel_r, sel_s;
    logic [ROW_W-1:0]  mrf_row_r, row_s;
    logic [XLEN-1:0]   mrf_wdata_r, wdata_s;
    logic              load_s;
    logic [XLEN-1:0]   buf_rd_s;
    logic [XLEN-1:0]   line_data_s;
    mwb_src_e          src_s;

    mwb_row_buffer #(
        .XLEN (XLEN),
        .ROWS (ROWS)
    ) u_row_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_rows (wb_matrix_mul_o[ROWS-1:1]),
        .rd_idx    (cnt_r),
        .rd_data   (buf_rd_s)
    );

    // Line source priority: memory load, then scalar register, then line data.
    always_comb begin
        if (wb_mem2matrix) begin
            src_s = SRC_MEM;
        end else if (wb_mem_reg2matrix) begin
            src_s = SRC_REG;
        end else begin
            src_s = SRC_LINE;
        end
        case (src_s)
            SRC_MEM:  line_data_s = wb_mem_data;
            SRC_REG:  line_data_s = wb_regs_data1;
            SRC_LINE: line_data_s = wb_matrix_line_data;
            default:  line_data_s = wb_matrix_line_data;
        endcase
    end

    // Next-state and next-output decode; sel/row/data hold when nothing is written.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        we_s    = 1'b0;
        sel_s   = mrf_sel_r;
        row_s   = mrf_row_r;
        wdata_s = mrf_wdata_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wb_matrix_write_mopa) begin
                    // Row 0 goes straight out; rows 1.. are parked in the buffer.
                    we_s    = 1'b1;
                    sel_s   = wb_matrix_index;
                    row_s   = '0;
                    wdata_s = wb_matrix_mul_o[0];
                    load_s  = 1'b1;
                    cnt_s   = ROW_W'(1);
                    state_s = ST_SEQ;
                end else if (wb_matrix_write) begin
                    we_s    = 1'b1;
                    sel_s   = wb_matrix_index;
                    row_s   = wb_matrix_row;
                    wdata_s = line_data_s;
                end else begin
                    we_s    = 1'b0;
                end
            end
            ST_SEQ: begin
                // Pipeline inputs are ignored here; sel keeps the captured index.
                we_s    = 1'b1;
                row_s   = cnt_r;
                wdata_s = buf_rd_s;
                if (cnt_r == LAST_ROW) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + ROW_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, row counter and registered MRF write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            mrf_we_r    <= 1'b0;
            mrf_sel_r   <= '0;
            mrf_row_r   <= '0;
            mrf_wdata_r <= '0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mrf_we_r    <= we_s;
            mrf_sel_r   <= sel_s;
            mrf_row_r   <= row_s;
            mrf_wdata_r <= wdata_s;
        end
    end

    assign mrf_we    = mrf_we_r;
    assign mrf_sel   = mrf_sel_r;
    assign mrf_row   = mrf_row_r;
    assign mrf_wdata = mrf_wdata_r;
    assign stall     = (state_r == ST_SEQ);
    assign busy      = (state_r != ST_IDLE) || mrf_we_r;

`ifdef MWB_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_r;

    // Saturating count of cycles spent stalling the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_r <= 32'h0000_0000;
        end else if (stall && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_r <= perf_stall_cnt_r + 32'h0000_0001;
        end else begin
            perf_stall_cnt_r <= perf_stall_cnt_r;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
`else
    // Stall counter not built in this configuration.
`endif

endmodule
